// File: rtl/register_4bit_pkg.sv
// Shared types and defaults for the register_4bit universal shift register.
package register_4bit_pkg;

    typedef enum logic [1:0] {
        MODE_LOAD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

    localparam int REG_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/register_4bit_if.sv
// Control/data bundle for register_4bit: the master drives load/s/i, the register returns o.
interface register_4bit_if
    import register_4bit_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH_DEFAULT
) ();

    logic             load;
    logic [1:0]       s;
    logic [WIDTH-1:0] i;
    logic [WIDTH-1:0] o;

    modport master (output load, output s, output i, input o);
    modport slave  (input load, input s, input i, output o);

endinterface

// File: rtl/register_4bit_next.sv
// Combinational next-state mux for register_4bit.
// REGISTER_4BIT_ROTATE_EN turns the shift modes into rotates.
module register_4bit_next
    import register_4bit_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] i,
    input  logic [1:0]       s,
    input  logic             load,
    output logic [WIDTH-1:0] nxt
);

    logic  shr_fill_s;
    logic  shl_fill_s;
    mode_t mode_s;

    assign mode_s = mode_t'(s);

`ifdef REGISTER_4BIT_ROTATE_EN
    assign shr_fill_s = cur[0];
    assign shl_fill_s = cur[WIDTH-1];
`else
    assign shr_fill_s = 1'b0;
    assign shl_fill_s = 1'b0;
`endif

    // Mode decode; any unknown select falls through to hold.
    always_comb begin
        nxt = cur;
        if (load) begin
            case (mode_s)
                MODE_LOAD: nxt = i;
                MODE_SHR:  nxt = {shr_fill_s, cur[WIDTH-1:1]};
                MODE_SHL:  nxt = {cur[WIDTH-2:0], shl_fill_s};
                MODE_HOLD: nxt = cur;
                default:   nxt = cur;
            endcase
        end else begin
            nxt = cur;
        end
    end

endmodule

// File: rtl/register_4bit.sv
// Universal shift register: flop bank with asynchronous active-high reset.
// Build option REGISTER_4BIT_ROTATE_EN (handled in register_4bit_next) selects rotate instead of zero-fill.
module register_4bit
    import register_4bit_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    register_4bit_if.slave bus
);

    logic [WIDTH-1:0] state_r;
    logic [WIDTH-1:0] nxt_s;

    register_4bit_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .cur  (state_r),
        .i    (bus.i),
        .s    (bus.s),
        .load (bus.load),
        .nxt  (nxt_s)
    );

    // State register; o is driven straight from the flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= {WIDTH{1'b0}};
        end else begin
            state_r <= nxt_s;
        end
    end

    assign bus.o = state_r;

endmodule

// File: tb/tb_register_4bit.sv
// Self-checking bench for register_4bit: directed table, hand-written reset/timing
// sequences and randomized traffic against an arithmetic reference model.
module tb_register_4bit;

    localparam int W = 4;
`ifdef REGISTER_4BIT_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic clk;
    logic reset;
    int   total;
    int   passed;
    logic [W-1:0] model;

    register_4bit_if #(.WIDTH(W)) bus ();

    register_4bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         ld;
        logic [1:0]   s;
        logic [W-1:0] i;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Reference: plain integer arithmetic on the register value.
    function automatic logic [W-1:0] ref_next(input logic [W-1:0] cur, input logic ld,
                                              input logic [1:0] s, input logic [W-1:0] i);
        int unsigned v;
        int unsigned mask;
        int unsigned r;
        v    = cur;
        mask = (1 << W) - 1;
        r    = v;
        if (ld && s == 2'd0) r = i;
        if (ld && s == 2'd1) r = (v >> 1) | (ROT ? ((v & 1) << (W - 1)) : 0);
        if (ld && s == 2'd2) r = ((v << 1) & mask) | (ROT ? (v >> (W - 1)) : 0);
        return r[W-1:0];
    endfunction

    task automatic step(input logic rst, input logic ld, input logic [1:0] s, input logic [W-1:0] i);
        @(negedge clk);
        reset    = rst;
        bus.load = ld;
        bus.s    = s;
        bus.i    = i;
        @(posedge clk);
        #1;
        model = rst ? '0 : ref_next(model, ld, s, i);
        check("model", bus.o, model);
    endtask

    initial begin
        total    = 0;
        passed   = 0;
        model    = '0;
        reset    = 1'b0;
        bus.load = 1'b1;
        bus.s    = 2'b00;
        bus.i    = 4'b0110;

        vecs[0]  = '{1'b1, 1'b1, 2'b00, 4'b0110, 4'b0000};
        vecs[1]  = '{1'b0, 1'b1, 2'b00, 4'b0110, 4'b0110};
        vecs[2]  = '{1'b0, 1'b1, 2'b01, 4'b0110, 4'b0011};
        vecs[3]  = '{1'b0, 1'b1, 2'b10, 4'b0110, 4'b0110};
        vecs[4]  = '{1'b0, 1'b1, 2'b11, 4'b0000, 4'b0110};
        vecs[5]  = '{1'b0, 1'b1, 2'b00, 4'b1001, 4'b1001};
        vecs[6]  = '{1'b0, 1'b1, 2'b01, 4'b1001, ROT ? 4'b1100 : 4'b0100};
        vecs[7]  = '{1'b0, 1'b1, 2'b00, 4'b1001, 4'b1001};
        vecs[8]  = '{1'b0, 1'b1, 2'b10, 4'b1001, ROT ? 4'b0011 : 4'b0010};
        vecs[9]  = '{1'b0, 1'b0, 2'b00, 4'b1111, ROT ? 4'b0011 : 4'b0010};
        vecs[10] = '{1'b0, 1'b0, 2'b01, 4'b1111, ROT ? 4'b0011 : 4'b0010};
        vecs[11] = '{1'b0, 1'b0, 2'b10, 4'b1111, ROT ? 4'b0011 : 4'b0010};
        vecs[12] = '{1'b0, 1'b0, 2'b11, 4'b1111, ROT ? 4'b0011 : 4'b0010};
        vecs[13] = '{1'b0, 1'b1, 2'b00, 4'b0110, 4'b0110};
        vecs[14] = '{1'b0, 1'b1, 2'b01, 4'b0000, 4'b0011};
        vecs[15] = '{1'b0, 1'b1, 2'b01, 4'b0000, ROT ? 4'b1001 : 4'b0001};
        vecs[16] = '{1'b0, 1'b1, 2'b01, 4'b0000, ROT ? 4'b1100 : 4'b0000};
        vecs[17] = '{1'b0, 1'b1, 2'b01, 4'b0000, ROT ? 4'b0110 : 4'b0000};

        // Reset asserted asynchronously before any clock edge, held over two edges.
        #1 reset = 1'b1;
        #1 check("reset_async", bus.o, 4'b0000);
        @(posedge clk); #1 check("reset_edge1", bus.o, 4'b0000);
        @(posedge clk); #1 check("reset_edge2", bus.o, 4'b0000);

        for (int k = 0; k < 18; k++) begin
            step(vecs[k].rst, vecs[k].ld, vecs[k].s, vecs[k].i);
            check($sformatf("vec%0d", k), bus.o, vecs[k].exp);
        end

        // Mid-operation reset between edges, then held against a load.
        step(1'b0, 1'b1, 2'b00, 4'b0110);
        check("pre_midreset", bus.o, 4'b0110);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("midreset_async", bus.o, 4'b0000);
        bus.load = 1'b1;
        bus.s    = 2'b00;
        bus.i    = 4'b1111;
        @(posedge clk); #1 check("midreset_hold", bus.o, 4'b0000);
        model = '0;
        step(1'b0, 1'b1, 2'b00, 4'b1010);
        check("first_load_after_reset", bus.o, 4'b1010);

        // Inputs changing after an edge do not reach o before the next edge.
        #1;
        bus.i = 4'b0101;
        bus.s = 2'b10;
        #2 check("between_edges", bus.o, 4'b1010);

        // Randomized traffic with occasional reset pulses.
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 19) == 0), 1'($urandom), 2'($urandom), W'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
